// File: rtl/div_unit_if.sv
// Request/result handshake bundle between the EX stage and the iterative divider.
interface div_unit_if;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_op;
    logic        i_is_32;
    logic [63:0] i_operand_a;
    logic [63:0] i_operand_b;
    logic        i_flush;
    logic        o_valid;
    logic [63:0] o_value;
    logic        i_ready;

    modport slave (
        input  i_valid, i_op, i_is_32, i_operand_a, i_operand_b, i_flush, i_ready,
        output o_ready, o_valid, o_value
    );

    modport master (
        output i_valid, i_op, i_is_32, i_operand_a, i_operand_b, i_flush, i_ready,
        input  o_ready, o_valid, o_value
    );
endinterface

// File: rtl/div_unit.sv
// Non-restoring radix-2 divider for RV64M DIV/DIVU/REM/REMU (+W), one op in flight.
// Optional DIV_EARLY_TERM_EN: bypass when |dividend| < |divisor|.
module div_unit #(
    parameter int ITER_PER_CYCLE = 1
) (
    input logic       clk,
    input logic       rstn,
    div_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, FIN, DONE} state_t;
    localparam int SH = ITER_PER_CYCLE - 1;

    state_t      state, state_nx;
    logic [64:0] rem_q, rem_nx;
    logic [63:0] quo_q, quo_nx, dvs_q, res_q;
    logic [65:0] trial;
    logic [6:0]  cnt;
    logic        is_rem_q, w_q, qneg_q, rneg_q;

    function automatic logic [63:0] wext(input logic w, input logic [63:0] v);
        return w ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

    // Operand preparation on the raw request
    logic        signed_op, a_neg, b_neg, div0, ovf, early, bypass, accept;
    logic [63:0] a_ext, b_ext, a_mag, b_mag, min_val, byp_res;

    always_comb begin
        signed_op = ~bus.i_op[0];
        a_ext = bus.i_is_32 ? {{32{signed_op & bus.i_operand_a[31]}}, bus.i_operand_a[31:0]}
                            : bus.i_operand_a;
        b_ext = bus.i_is_32 ? {{32{signed_op & bus.i_operand_b[31]}}, bus.i_operand_b[31:0]}
                            : bus.i_operand_b;
        a_neg = signed_op & a_ext[63];
        b_neg = signed_op & b_ext[63];
        a_mag = a_neg ? -a_ext : a_ext;
        b_mag = b_neg ? -b_ext : b_ext;
        min_val = bus.i_is_32 ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        div0 = (b_ext == 64'd0);
        ovf  = signed_op & (a_ext == min_val) & (&b_ext);
`ifdef DIV_EARLY_TERM_EN
        early = ~div0 & (a_mag < b_mag);
`else
        early = 1'b0;
`endif
        bypass = div0 | ovf | early;
        if (div0)
            byp_res = bus.i_op[1] ? a_ext : '1;
        else if (ovf)
            byp_res = bus.i_op[1] ? 64'd0 : a_ext;
        else
            byp_res = bus.i_op[1] ? a_ext : 64'd0;
        byp_res = wext(bus.i_is_32, byp_res);
    end

    assign bus.o_ready = (state == IDLE);
    assign bus.o_valid = (state == DONE);
    assign bus.o_value = bus.o_valid ? res_q : 64'd0;
    assign accept      = bus.i_valid & bus.o_ready & ~bus.i_flush;

    // Partial remainder stays in [-d, d); the shifted trial needs one extra bit
    always_comb begin
        rem_nx = rem_q;
        quo_nx = quo_q;
        trial  = '0;
        for (int k = 0; k < ITER_PER_CYCLE; k++) begin
            trial  = {rem_nx, quo_nx[63]};
            trial  = rem_nx[64] ? trial + {2'b00, dvs_q} : trial - {2'b00, dvs_q};
            rem_nx = trial[64:0];
            quo_nx = {quo_nx[62:0], ~trial[65]};
        end
    end

    logic [63:0] rem_fix, qmag, qval, rval, fin_res;
    always_comb begin
        rem_fix = rem_q[64] ? rem_q[63:0] + dvs_q : rem_q[63:0];
        qmag    = w_q ? {32'd0, quo_q[31:0]} : quo_q;
        qval    = qneg_q ? -qmag : qmag;
        rval    = rneg_q ? -rem_fix : rem_fix;
        fin_res = wext(w_q, is_rem_q ? rval : qval);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (bus.i_flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: if (accept) state_nx = bypass ? DONE : BUSY;
                BUSY: if (cnt == 7'd1) state_nx = FIN;
                FIN:  state_nx = DONE;
                DONE: if (bus.i_ready) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            res_q    <= '0;
            cnt      <= '0;
            is_rem_q <= 1'b0;
            w_q      <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
        end else if (bus.i_flush) begin
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    // W dividends are pre-shifted so only N steps are needed
                    dvs_q    <= b_mag;
                    quo_q    <= bus.i_is_32 ? {a_mag[31:0], 32'd0} : a_mag;
                    rem_q    <= '0;
                    cnt      <= bus.i_is_32 ? 7'(32 >> SH) : 7'(64 >> SH);
                    is_rem_q <= bus.i_op[1];
                    w_q      <= bus.i_is_32;
                    qneg_q   <= a_neg ^ b_neg;
                    rneg_q   <= a_neg;
                    if (bypass) res_q <= byp_res;
                end
                BUSY: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt   <= cnt - 7'd1;
                end
                FIN:  res_q <= fin_res;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Scoreboarded bench for div_unit: directed cases, flush/backpressure/reset, random ops.
module tb_div_unit;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    div_unit_if bus();
    div_unit dut (.clk(clk), .rstn(rstn), .bus(bus));

    typedef struct { logic [63:0] val; int lat; } exp_t;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Reference: SV arithmetic plus the RISC-V special cases
    function automatic exp_t model(input logic [1:0] op, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        exp_t e;
        logic sgn;
        logic [63:0] ae, be, q, r, mn, ma, mb;
        bit fast;
        sgn = ~op[0];
        ae = w ? (sgn ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]}) : a;
        be = w ? (sgn ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]}) : b;
        mn = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        ma = (sgn && ae[63]) ? -ae : ae;
        mb = (sgn && be[63]) ? -be : be;
        fast = 0;
        if (be == 0) begin
            q = '1; r = ae; fast = 1;
        end else if (sgn && ae == mn && be == '1) begin
            q = ae; r = 0; fast = 1;
        end else if (sgn) begin
            q = $signed(ae) / $signed(be);
            r = $signed(ae) % $signed(be);
        end else begin
            q = ae / be;
            r = ae % be;
        end
`ifdef DIV_EARLY_TERM_EN
        if (be != 0 && ma < mb) fast = 1;
`endif
        e.val = op[1] ? r : q;
        if (w) e.val = {{32{e.val[31]}}, e.val[31:0]};
        e.lat = fast ? 0 : (w ? 33 : 65);
        return e;
    endfunction

    task automatic drive_req(input logic [1:0] op, input logic w,
                             input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        bus.i_valid = 1'b1; bus.i_op = op; bus.i_is_32 = w;
        bus.i_operand_a = a; bus.i_operand_b = b;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        bus.i_operand_a = '0; bus.i_operand_b = '0;
        sb.push_back(model(op, w, a, b));
    endtask

    task automatic run_op(input logic [1:0] op, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input int hold, output logic [63:0] got);
        int cyc;
        exp_t e;
        logic [63:0] held;
        drive_req(op, w, a, b);
        cyc = 0;
        while (!bus.o_valid && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        e = sb.pop_front();
        got = bus.o_value;
        chk("latency", 64'(cyc), 64'(e.lat));
        chk("value", bus.o_value, e.val);
        held = bus.o_value;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_value", bus.o_value, held);
            chk("hold_ready", 64'(bus.o_ready), 64'd0);
        end
        bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
        chk("consumed", 64'(bus.o_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] got;
        exp_t drop;
        int seen;
        bus.i_valid = 0; bus.i_op = 0; bus.i_is_32 = 0; bus.i_operand_a = 0;
        bus.i_operand_b = 0; bus.i_flush = 0; bus.i_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(bus.o_ready), 64'd1);
        chk("rst_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_value", bus.o_value, 64'd0);
        @(negedge clk); rstn = 1'b1;

        run_op(2'b00, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, got);
        chk("div_m7_2", got, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'b10, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, got);
        chk("rem_m7_2", got, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(2'b01, 0, 64'd100, 64'd0, 0, got);
        chk("divu_by0", got, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op(2'b11, 0, 64'd100, 64'd0, 0, got);
        chk("remu_by0", got, 64'd100);
        run_op(2'b00, 1, 64'h0000_0000_8000_0000, '1, 0, got);
        chk("divw_ovf", got, 64'hFFFF_FFFF_8000_0000);
        run_op(2'b10, 1, 64'h0000_0000_8000_0000, '1, 0, got);
        chk("remw_ovf", got, 64'd0);
        run_op(2'b01, 1, 64'hDEAD_BEEF_FFFF_FFFE, 64'd2, 0, got);
        chk("divuw", got, 64'h0000_0000_7FFF_FFFF);
        run_op(2'b11, 0, 64'd5, 64'd9, 0, got);
        chk("remu_5_9", got, 64'd5);
        run_op(2'b00, 0, 64'h8000_0000_0000_0000, '1, 0, got);
        chk("div_ovf64", got, 64'h8000_0000_0000_0000);

        // Backpressure in DONE
        run_op(2'b01, 0, 64'd1000, 64'd7, 10, got);
        chk("bp_value", got, 64'd142);

        // Flush in BUSY cycle 20
        drive_req(2'b00, 0, 64'd12345, 64'd3);
        drop = sb.pop_back();
        repeat (19) @(posedge clk);
        #1 bus.i_flush = 1'b1;
        @(posedge clk); #1;
        bus.i_flush = 1'b0;
        chk("flush_ready", 64'(bus.o_ready), 64'd1);
        chk("flush_valid", 64'(bus.o_valid), 64'd0);
        seen = 0;
        repeat (70) begin @(posedge clk); #1; if (bus.o_valid) seen++; end
        chk("flush_novalid", 64'(seen), 64'd0);

        // Flush with request: must not be accepted
        @(negedge clk);
        bus.i_valid = 1; bus.i_flush = 1; bus.i_op = 2'b01; bus.i_is_32 = 0;
        bus.i_operand_a = 64'd100; bus.i_operand_b = 64'd0;
        @(posedge clk); #1;
        bus.i_valid = 0; bus.i_flush = 0;
        chk("flushreq_valid", 64'(bus.o_valid), 64'd0);
        chk("flushreq_ready", 64'(bus.o_ready), 64'd1);

        // Flush in DONE with i_ready: result discarded
        drive_req(2'b01, 0, 64'd100, 64'd0);
        drop = sb.pop_back();
        chk("done_valid", 64'(bus.o_valid), 64'd1);
        bus.i_flush = 1; bus.i_ready = 1;
        @(posedge clk); #1;
        bus.i_flush = 0; bus.i_ready = 0;
        chk("flushdone_valid", 64'(bus.o_valid), 64'd0);
        chk("flushdone_value", bus.o_value, 64'd0);

        // Reset mid-operation
        drive_req(2'b00, 0, 64'd999, 64'd4);
        drop = sb.pop_back();
        repeat (10) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("rstbusy_valid", 64'(bus.o_valid), 64'd0);
        chk("rstbusy_ready", 64'(bus.o_ready), 64'd1);
        @(negedge clk); rstn = 1'b1;
        seen = 0;
        repeat (70) begin @(posedge clk); #1; if (bus.o_valid) seen++; end
        chk("rstbusy_novalid", 64'(seen), 64'd0);

        // Random mix
        for (int i = 0; i < 24; i++) begin
            logic [63:0] a, b;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: b = 64'($urandom_range(0, 20));
                1: a = 64'($urandom_range(0, 20));
                2: b = 64'($signed(-($urandom_range(1, 9))));
                default: ;
            endcase
            run_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, b, 0, got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative integer divider for RV64M DIV/DIVU/REM/REMU and the 32-bit W forms.
- Receives the two operands that the EX stage forwards unchanged for DIV-type ops (rs1 as operand A, rs2 as operand B).
- Returns one 64-bit result to stage 2 over a valid/ready handshake.
- Non-restoring radix-2 core with special-case bypass; one operation in flight.

Parameters:
- ITER_PER_CYCLE, 1, quotient bits retired per BUSY cycle; legal values 1 or 2.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- i_valid  input  1  operation request
- o_ready  output  1  unit can accept a request
- i_op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU
- i_is_32  input  1  W-form operation
- i_operand_a  input  64  dividend (rs1)
- i_operand_b  input  64  divisor (rs2)
- i_flush  input  1  kill the in-flight or pending operation
- o_valid  output  1  result available
- o_value  output  64  quotient or remainder
- i_ready  input  1  consumer takes the result

Behaviour:
- States: IDLE, BUSY, DONE. Reset (async, rstn=0) values:
  - state=IDLE, o_ready=1, o_valid=0, o_value=0, iteration counter=0.
- Accept: a request is accepted on a rising edge where i_valid & o_ready & !i_flush.
  - o_ready=1 only in IDLE.
  - Operands and op are captured at the accepting edge; inputs are don't-care afterwards.
- Operand prep:
  - W form: use bits [31:0], sign-extend them for DIV/REM and zero-extend them for DIVU/REMU.
  - Width N=32 for W, otherwise 64.
  - Signed ops divide the magnitudes. Quotient is negated when the operand signs differ; remainder takes the sign of the dividend.
- Special cases are decided at the accepting edge. They go IDLE->DONE directly, so o_valid is high in the next cycle:
  - Divisor==0: quotient = all ones (-1); remainder = dividend.
  - Signed overflow (dividend = most-negative N-bit value, divisor = -1): quotient = dividend; remainder = 0.
- Normal path:
  - IDLE->BUSY.
  - BUSY lasts N/ITER_PER_CYCLE cycles, with the counter decrementing by one per cycle.
  - One further finalise cycle applies sign correction and selects the result.
  - Then DONE. o_valid first goes high N/ITER_PER_CYCLE+1 cycles after the accepting edge (DIV 64-bit, ITER=1: 65 cycles).
- W result: bits [31:0] of the N-bit result, sign-extended to 64 bits (for all four ops, per the ISA).
- DONE:
  - o_valid=1 and o_value is stable until a handshake.
  - When o_valid & i_ready: go to IDLE, and o_valid=0 next cycle.
  - No new accept in the same cycle as the handshake (o_ready=0 in DONE).
- Flush:
  - i_flush=1 in any state sends the block to IDLE on the next edge with o_valid=0 and no result.
  - Flush in the same cycle as i_valid: the request is not accepted.
  - Flush in DONE while i_ready=1: the result is discarded and is not considered consumed.
- Reset mid-operation: the block returns immediately to reset values; no residual result.
- o_value is driven 0 when o_valid=0.

Optional Feature:
- Macro DIV_EARLY_TERM_EN.
- Defined:
  - At the accepting edge, if |dividend| < |divisor| (unsigned compare of the prepared magnitudes, divisor non-zero), the op bypasses like a special case.
  - Result is quotient=0 and remainder=dividend (W-form sign-extended), with o_valid high on the next cycle.
  - Dividend==0 is covered by this rule.
- Undefined: no early termination; such operations take the full N/ITER_PER_CYCLE+1 latency with identical results.

Test Plan:
- DIV a=-7 (0xFFFF_FFFF_FFFF_FFF9), b=2, 64-bit, ITER=1 -> o_valid exactly 65 cycles after accept, o_value=0xFFFF_FFFF_FFFF_FFFD (-3); same operands with REM -> 0xFFFF_FFFF_FFFF_FFFF (-1).
- DIVU a=100, b=0 -> o_valid next cycle, o_value=0xFFFF_FFFF_FFFF_FFFF; REMU a=100, b=0 -> o_value=100.
- DIV W a=0x0000_0000_8000_0000, b=0xFFFF_FFFF_FFFF_FFFF -> overflow bypass, o_value=0xFFFF_FFFF_8000_0000; REM W same operands -> 0.
- DIVU W a=0xDEAD_BEEF_FFFF_FFFE, b=0x0000_0000_0000_0002 -> o_valid 33 cycles after accept, o_value=0x0000_0000_7FFF_FFFF.
- Backpressure and flush: hold i_ready=0 for 10 cycles in DONE -> o_value stable, o_ready=0. Assert i_flush in BUSY cycle 20 -> IDLE next cycle, o_valid never asserts, o_ready=1. Assert i_flush together with i_valid -> request not accepted.
- With DIV_EARLY_TERM_EN: REMU a=5, b=9 -> o_valid next cycle, o_value=5. Without the macro -> same value after 65 cycles. Deassert rstn in BUSY -> o_valid=0, o_ready=1 immediately.
